// File: rtl/lsu_mem_master_if.sv
// Bundles the CPU-side request/response handshake and the data-memory port of the
// load/store initiator so both sides connect through a single port.
interface lsu_mem_master_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    // Seen from the load/store unit itself.
    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_read, mem_write, mem_address, mem_write_data,
        input  mem_read_data
    );

    // Seen from the pipeline and the data memory.
    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_read, mem_write, mem_address, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one byte/half/word access at a time against a word-organised
// memory, with alignment checking and read-modify-write for sub-word stores.
//
// state    | meaning
// IDLE     | ready for a request, no memory access
// READ     | mem_read high; load lane select or store merge source captured
// WRITE    | mem_write high; full word committed at end of cycle
// RESP     | one-cycle response pulse with latched rdata/err
module lsu_mem_master #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_mem_master_if.master  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]        state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lo,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
            SZ_HALF: r = {{16{h[15] & ~uns}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Little-endian lane replacement; untouched lanes keep the value just read.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] data,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lo);
        logic [31:0] r;
        r = word;
        if (size == SZ_HALF) begin
            if (lo[1]) r[31:16] = data[15:0];
            else       r[15:0]  = data[15:0];
        end else begin
            case (lo)
                2'd0:    r[7:0]   = data[7:0];
                2'd1:    r[15:8]  = data[7:0];
                2'd2:    r[23:16] = data[7:0];
                default: r[31:24] = data[7:0];
            endcase
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    if (is_illegal(bus.req_size, bus.req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (bus.req_write && bus.req_size == SZ_WORD) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (write_q) begin
                    wdata_d = store_merge(bus.mem_read_data, wdata_q, size_q, addr_q[1:0]);
                    state_d = ST_WRITE;
                end else begin
                    rdata_d = load_extract(bus.mem_read_data, size_q, addr_q[1:0], uns_q);
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory strobes decode straight from the state register so an async reset
    // removes a pending write before the edge that would commit it.
    assign bus.req_ready      = (state_q == ST_IDLE);
    assign bus.resp_valid     = (state_q == ST_RESP);
    assign bus.resp_rdata     = (state_q == ST_RESP) ? rdata_q : 32'h0;
    assign bus.resp_err       = (state_q == ST_RESP) & err_q;
    assign bus.mem_read       = (state_q == ST_READ);
    assign bus.mem_write      = (state_q == ST_WRITE);
    assign bus.mem_address    = (state_q == ST_IDLE) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_write_data = (state_q == ST_WRITE) ? wdata_q : 32'h0;

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator between the CPU's MEM stage and the word-organised data memory (combinational read, posedge write, word-addressed via address[31:2]). Accepts one byte/halfword/word load or store, enforces natural alignment, and performs sub-word stores as read-modify-write. Returns sign- or zero-extended load data with a one-cycle response pulse.

## Interface
Parameters:
- ADDR_W, 32, byte-address width on both sides

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  pipeline presents a request
- req_ready  out  1  block can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse, request complete
- resp_rdata  out  32  extended load data; 0 for stores/errors
- resp_err  out  1  misaligned or illegal size, valid with resp_valid
- mem_read  out  1  to data memory
- mem_write  out  1  to data memory
- mem_address  out  ADDR_W  word-aligned: {req_addr[ADDR_W-1:2], 2'b00}
- mem_write_data  out  32  full word to write
- mem_read_data  in  32  combinational read data from memory

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch write/size/unsigned/addr/wdata.
  - Illegal: size 11, half with addr[0]=1, word with addr[1:0]!=0 → RESP, err=1, no memory access.
  - Load → READ. Word store → WRITE. Byte/half store → READ.
- READ: mem_read=1. Capture mem_read_data at end of cycle.
  - Load: select lane (little-endian; byte lane = addr[1:0], half lane = addr[1]), extend per unsigned → RESP.
  - Sub-word store: merge wdata[7:0] / wdata[15:0] into captured word at selected lane, others unchanged → WRITE.
- WRITE: mem_write=1, mem_write_data = merged word (or req_wdata for word stores) → RESP.
- RESP: resp_valid=1 with latched rdata/err → IDLE. No response backpressure.
- mem_read/mem_write are Moore outputs decoded from state only; never both high; both low in IDLE and RESP.
- mem_address held constant from leaving IDLE until return to IDLE; 0 in IDLE.

## Timing
- Reset (async, immediate): state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; mem_read=0, mem_write=0, mem_address=0, mem_write_data=0. Reset asserted during WRITE drops mem_write before the next edge: no memory write occurs.
- Accept at edge N (req_valid & IDLE). Latencies to resp_valid high:
  - Error: cycle N+1.
  - Load, word store: N+2.
  - Sub-word store: N+3 (READ N+1, WRITE N+2, RESP N+3).
- Memory write commits at the rising edge ending the WRITE cycle.
- req_ready low from cycle N+1 through RESP; next accept earliest in the cycle after RESP.
- req_valid while not ready is ignored; request inputs only sampled in IDLE.
- Sign extension uses bit 7 (byte) or bit 15 (half) of selected lane.

## Test plan
- Reset: hold rst_n=0 mid-WRITE → mem_write falls asynchronously, memory word unchanged; all outputs at reset values; req_ready=1.
- Word load addr 0x100, memory word 0x00000004 → mem_read high cycle N+1, resp_valid at N+2, rdata=0x00000004, err=0.
- Byte loads of word 0x80FF7F01 at addr 0x104..0x107: signed → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; unsigned addr 0x106 → 0x000000FF.
- Half store wdata 0x1234ABCD to addr 0x10A over word 0x11223344 → READ then WRITE, mem_write_data=0xABCD3344, resp_valid at N+3; readback word = 0xABCD3344.
- Misaligned: word load addr 0x102, half store addr 0x101, size 11 → resp_err=1 at N+1, rdata=0, mem_read/mem_write never asserted.
- Back-to-back: req_valid held high for word store 0x5 to 0x110 then load 0x110 → second accept only after RESP, load returns 0x00000005.
